// File: rtl/dragon_head_ctrl_if.sv
// Bus between the dragon head controller and its frame/target source.
// Carries frame strobe, enable, target and the head/counter outputs.
interface dragon_head_ctrl_if;
    logic       vsync;
    logic       enable;
    logic [7:0] target_pos;
    logic [9:0] Dragon_Head;
    logic [5:0] movementCounter;
    logic       step_pulse;
    logic       at_target;

    modport master (
        output vsync,
        output enable,
        output target_pos,
        input  Dragon_Head,
        input  movementCounter,
        input  step_pulse,
        input  at_target
    );

    modport slave (
        input  vsync,
        input  enable,
        input  target_pos,
        output Dragon_Head,
        output movementCounter,
        output step_pulse,
        output at_target
    );
endinterface

// File: rtl/dragon_head_ctrl.sv
// Dragon head controller: counts frames, then steps the head one cell
// toward the target along the longer axis (ties go to x).
module dragon_head_ctrl #(
    parameter logic [5:0] MOVE_PERIOD = 6'd10,
    parameter logic [7:0] START_POS   = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    dragon_head_ctrl_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] STEP  = 2'd2;

    logic [1:0] state;
    logic       pre_vsync;
    logic       tick;

    logic [3:0] hx;
    logic [3:0] hy;
    logic [3:0] tx;
    logic [3:0] ty;
    logic [4:0] dx;
    logic [4:0] dy;
    logic [4:0] ndx;
    logic [4:0] ndy;
    logic [3:0] adx;
    logic [3:0] ady;
    logic [9:0] next_head;
    logic       next_at;

    assign hx   = bus.Dragon_Head[7:4];
    assign hy   = bus.Dragon_Head[3:0];
    assign tx   = bus.target_pos[7:4];
    assign ty   = bus.target_pos[3:0];
    assign tick = bus.vsync & ~pre_vsync;

    // Signed distance to target and its magnitude per axis
    always_comb begin
        dx  = {1'b0, tx} - {1'b0, hx};
        dy  = {1'b0, ty} - {1'b0, hy};
        ndx = 5'd0 - dx;
        ndy = 5'd0 - dy;
        adx = dx[4] ? ndx[3:0] : dx[3:0];
        ady = dy[4] ? ndy[3:0] : dy[3:0];
    end

    // One-cell move toward target; a tie means the x axis moves first
    always_comb begin
        next_head = bus.Dragon_Head;
        next_at   = 1'b1;
        if ((adx != 4'd0) || (ady != 4'd0)) begin
            if (adx >= ady) begin
                if (dx[4]) begin
                    next_head[7:4] = hx - 4'd1;
                    next_head[9:8] = 2'b11;
                end else begin
                    next_head[7:4] = hx + 4'd1;
                    next_head[9:8] = 2'b01;
                end
            end else begin
                if (dy[4]) begin
                    next_head[3:0] = hy - 4'd1;
                    next_head[9:8] = 2'b00;
                end else begin
                    next_head[3:0] = hy + 4'd1;
                    next_head[9:8] = 2'b10;
                end
            end
            next_at = (next_head[7:0] == bus.target_pos);
        end
    end

    // Frame edge detector; starts high so a held vsync gives no tick
    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_vsync <= 1'b1;
        end else begin
            pre_vsync <= bus.vsync;
        end
    end

    // Frame counting, head stepping and status flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            state               <= IDLE;
            bus.Dragon_Head     <= {2'b00, START_POS};
            bus.movementCounter <= 6'd0;
            bus.step_pulse      <= 1'b0;
            bus.at_target       <= 1'b0;
        end else begin
            bus.step_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.enable) begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (!bus.enable) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (bus.movementCounter == MOVE_PERIOD) begin
                            bus.movementCounter <= 6'd0;
                            state               <= STEP;
                        end else if (bus.movementCounter > MOVE_PERIOD) begin
                            bus.movementCounter <= 6'd0;
                        end else begin
                            bus.movementCounter <= bus.movementCounter + 6'd1;
                        end
                    end
                end
                STEP: begin
                    if (!bus.enable) begin
                        state <= IDLE;
                    end else begin
                        bus.Dragon_Head <= next_head;
                        bus.at_target   <= next_at;
                        bus.step_pulse  <= 1'b1;
                        state           <= COUNT;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dragon_head_ctrl.sv
// Randomized bench for dragon_head_ctrl with a behavioural model.
// Directed scenarios first, then random vsync/enable/target/reset.
module tb_dragon_head_ctrl;

    localparam int MP = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    dragon_head_ctrl_if bus ();

    dragon_head_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    int m_hx, m_hy, m_or, m_cnt, m_mode, m_pv, m_sp, m_at;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model of one clock edge: mode 0 idle, 1 counting, 2 step due
    task automatic model_edge(input logic r, input logic v,
                              input logic e, input logic [7:0] t);
        int tx, ty, dx, dy, adx, ady;
        bit tk;
        if (!r) begin
            m_hx = 0; m_hy = 0; m_or = 0; m_cnt = 0;
            m_mode = 0; m_pv = 1; m_sp = 0; m_at = 0;
            return;
        end
        tk = (v == 1'b1) && (m_pv == 0);
        m_pv = int'(v);
        m_sp = 0;
        tx = int'(t[7:4]);
        ty = int'(t[3:0]);
        if (m_mode == 0) begin
            if (e) m_mode = 1;
        end else if (!e) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (tk) begin
                if (m_cnt == MP) begin
                    m_cnt = 0;
                    m_mode = 2;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end else begin
            dx = tx - m_hx;
            dy = ty - m_hy;
            adx = (dx < 0) ? -dx : dx;
            ady = (dy < 0) ? -dy : dy;
            if (dx == 0 && dy == 0) begin
                m_at = 1;
            end else begin
                if (adx >= ady) begin
                    if (dx > 0) begin m_hx++; m_or = 1; end
                    else begin m_hx--; m_or = 3; end
                end else begin
                    if (dy > 0) begin m_hy++; m_or = 2; end
                    else begin m_hy--; m_or = 0; end
                end
                m_at = (m_hx == tx && m_hy == ty) ? 1 : 0;
            end
            m_sp = 1;
            m_mode = 1;
        end
    endtask

    logic [7:0] tgt;

    task automatic cyc(input logic r, input logic v, input logic e);
        reset = r;
        bus.vsync = v;
        bus.enable = e;
        bus.target_pos = tgt;
        @(posedge clk);
        model_edge(r, v, e, tgt);
        #1;
        chk("head", 32'(bus.Dragon_Head), 32'(m_or * 256 + m_hx * 16 + m_hy));
        chk("cnt", 32'(bus.movementCounter), 32'(m_cnt));
        chk("step_pulse", 32'(bus.step_pulse), 32'(m_sp));
        chk("at_target", 32'(bus.at_target), 32'(m_at));
    endtask

    task automatic pulses(input int n, input logic e);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, e);
            cyc(1'b1, 1'b1, e);
        end
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("rst_head", 32'(bus.Dragon_Head), 32'h000);
        chk("rst_cnt", 32'(bus.movementCounter), 32'd0);
        chk("rst_sp", 32'(bus.step_pulse), 32'd0);
        chk("rst_at", 32'(bus.at_target), 32'd0);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        chk("rst_notick", 32'(bus.movementCounter), 32'd0);
    endtask

    initial begin
        tgt = 8'h30;
        reset = 1'b0;
        bus.vsync = 1'b1;
        bus.enable = 1'b1;
        bus.target_pos = tgt;

        do_reset();
        pulses(10, 1'b1);
        chk("r030_cnt10", 32'(bus.movementCounter), 32'd10);
        pulses(1, 1'b1);
        chk("r030_cnt0", 32'(bus.movementCounter), 32'd0);
        chk("r030_hold", 32'(bus.Dragon_Head), 32'h000);
        cyc(1'b1, 1'b0, 1'b1);
        chk("r030_head", 32'(bus.Dragon_Head), 32'h110);
        chk("r030_sp", 32'(bus.step_pulse), 32'd1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("r030_sp_off", 32'(bus.step_pulse), 32'd0);

        tgt = 8'h22;
        do_reset();
        pulses(11, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("r031_h1", 32'(bus.Dragon_Head[7:0]), 32'h10);
        pulses(11, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("r031_h2", 32'(bus.Dragon_Head[7:0]), 32'h11);
        pulses(11, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("r031_h3", 32'(bus.Dragon_Head[7:0]), 32'h21);
        chk("r031_at3", 32'(bus.at_target), 32'd0);
        pulses(11, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("r031_h4", 32'(bus.Dragon_Head[7:0]), 32'h22);
        chk("r031_at4", 32'(bus.at_target), 32'd1);

        pulses(11, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("r032_head", 32'(bus.Dragon_Head), 32'h222);
        chk("r032_sp", 32'(bus.step_pulse), 32'd1);
        chk("r032_at", 32'(bus.at_target), 32'd1);

        tgt = 8'h00;
        pulses(11, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("r033_s1", 32'(bus.Dragon_Head), 32'h312);
        pulses(11, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("r033_s2", 32'(bus.Dragon_Head), 32'h011);
        pulses(22, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("r033_end", 32'(bus.Dragon_Head), 32'h000);
        chk("r033_at", 32'(bus.at_target), 32'd1);

        tgt = 8'h55;
        pulses(10, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("r034_cnt", 32'(bus.movementCounter), 32'd10);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("r034_head", 32'(bus.Dragon_Head), 32'h000);
        pulses(1, 1'b1);
        chk("r034_resume", 32'(bus.movementCounter), 32'd0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("r034_step", 32'(bus.Dragon_Head), 32'h110);

        pulses(11, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("r035_head", 32'(bus.Dragon_Head), 32'h000);
        chk("r035_sp", 32'(bus.step_pulse), 32'd0);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        chk("r035_notick", 32'(bus.movementCounter), 32'd0);
        pulses(1, 1'b1);
        chk("r035_tick", 32'(bus.movementCounter), 32'd1);

        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 149) == 0) tgt = 8'($urandom);
            cyc(($urandom_range(0, 799) != 0),
                1'($urandom),
                ($urandom_range(0, 39) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
